instruction_fetch_queue: RTL and testbench
==========================================

// Module: instruction_fetch_queue
// PURPOSE
// - Prefetch FIFO between the instruction fetch unit and the decode stage.
// - Buffers {Instruction, PCAddResult} pairs so fetch runs ahead of decode stalls.
// - Flush discards all buffered entries on a taken branch or jump.
// - Empty queue presents a MIPS NOP (0x00000000) to decode.
// PARAMETERS
// - DEPTH   4   number of entries; must be a power of 2, minimum 2
// - PTR_W   2   log2(DEPTH); width of the read/write pointers
// - DATA_W  32  width of Instruction and of PCAddResult
// PORTS
// - Clk             in   1         single clock; all state updates on the rising edge
// - Reset           in   1         synchronous, active-high; clears the queue
// - InValid         in   1         fetch presents a valid entry this cycle
// - InReady         out  1         queue accepts an entry this cycle
// - InInstruction   in   DATA_W    instruction word from fetch
// - InPCAddResult   in   DATA_W    PC+4 paired with InInstruction
// - Flush           in   1         discard all entries (taken branch or jump)
// - OutValid        out  1         head entry is valid
// - OutReady        in   1         decode consumes the head this cycle
// - OutInstruction  out  DATA_W    head instruction; 0 when empty
// - OutPCAddResult  out  DATA_W    head PC+4; 0 when empty
// - Count           out  PTR_W+1   number of occupied entries, 0..DEPTH
// BEHAVIOUR
// - Reset (sync): wr_ptr=0, rd_ptr=0, Count=0.
// - Outputs after reset: OutValid=0, InReady=1, OutInstruction=0, OutPCAddResult=0.
// - Handshake signals:
//   - push = InValid & InReady
//   - pop  = OutValid & OutReady
//   - InReady  = (Count != DEPTH)
//   - OutValid = (Count != 0)
// - InReady is not raised by a same-cycle pop. When full, a push waits one cycle.
// - Show-ahead read: head data drives the outputs combinationally from storage[rd_ptr].
// - Write-to-read latency is 1 cycle. An entry pushed at edge N is visible after edge N, with no same-cycle bypass.
// - Outputs when Count==0 are forced to 0 regardless of stale storage.
// - Push: write storage[wr_ptr] <= {InInstruction, InPCAddResult}; wr_ptr <= wr_ptr+1.
// - Pop: rd_ptr <= rd_ptr+1.
// - Pointers wrap modulo DEPTH (natural PTR_W-bit overflow).
// - Count updates:
//   - push & !pop: Count+1
//   - pop & !push: Count-1
//   - push & pop: unchanged
//   - neither: unchanged
// - Simultaneous push and pop on a non-empty, non-full queue: both happen, Count is unchanged.
// - Push on an empty queue with OutReady=1: no pop that cycle, because OutValid=0. Count becomes 1.
// - Flush (sync) has priority over push and pop. Next cycle: wr_ptr=rd_ptr=0, Count=0.
//   - A push in the same cycle as Flush is dropped.
//   - Storage contents are don't-care after a flush.
// - Reset has priority over Flush. Reset asserted mid-stream empties the queue on the next edge.
// - Ignored inputs:
//   - InValid while InReady=0 is ignored; fetch must hold its data.
//   - OutReady while OutValid=0 is ignored.
// - No state machine beyond the pointers and counter. Count is the single source of truth for full and empty.
// TESTING
// - Reset -> Count=0, OutValid=0, InReady=1, OutInstruction=0x00000000.
// - Push 0x8C010004/0x00000004, then next cycle pop -> outputs show that pair, then Count=0.
// - Push 4 entries (PC+4 = 4,8,C,10) with OutReady=0 -> InReady=0 and Count=4.
//   - A fifth push is ignored.
//   - Popping 4 returns them in order 4,8,C,10.
// - With Count=2, push and pop in the same cycle for 6 cycles -> Count stays 2.
//   - Pointers wrap past 3 to 0.
//   - Output order matches input order.
// - Count=3, Flush=1 with InValid=1 -> next cycle Count=0, OutValid=0, and the pushed word is absent.
// - Reset=1 while full and OutReady=1 -> next cycle Count=0, and no stale entry is ever presented afterwards.

Source files
------------

// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue
//   Prefetch FIFO between the instruction fetch unit and the decode stage.
//   Holds {instruction, PC+4} pairs so fetch can run ahead of decode stalls.
//   A flush (taken branch/jump) discards everything buffered. When empty, the
//   head outputs read as a MIPS NOP (all zeros).
//
// Ports
//   Clk            : single clock, rising edge
//   Reset          : synchronous active-high clear
//   InValid/InReady: fetch-side handshake, push = InValid & InReady
//   InInstruction  : instruction word from fetch
//   InPCAddResult  : PC+4 paired with InInstruction
//   Flush          : synchronous discard of all entries
//   OutValid/OutReady: decode-side handshake, pop = OutValid & OutReady
//   OutInstruction : head instruction (show-ahead), zero when empty
//   OutPCAddResult : head PC+4 (show-ahead), zero when empty
//   Count          : number of occupied entries, 0..DEPTH
//
// DEPTH must be a power of two (>= 2) and PTR_W = log2(DEPTH) so that the
// pointers wrap naturally on overflow.

module instruction_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              InValid,
  output logic              InReady,
  input  logic [DATA_W-1:0] InInstruction,
  input  logic [DATA_W-1:0] InPCAddResult,
  input  logic              Flush,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] OutInstruction,
  output logic [DATA_W-1:0] OutPCAddResult,
  output logic [PTR_W:0]    Count
);

  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ZERO   = {(PTR_W + 1){1'b0}};
  localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO   = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  logic [DATA_W-1:0] instr_mem_r [DEPTH];
  logic [DATA_W-1:0] pc_mem_r    [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W:0]    count_r;

  logic              push_s;
  logic              pop_s;
  logic              empty_s;

  // Count alone decides full/empty; a same-cycle pop never opens InReady.
  assign empty_s  = (count_r == CNT_ZERO);
  assign InReady  = (count_r != FULL_COUNT);
  assign OutValid = !empty_s;
  assign push_s   = InValid & InReady;
  assign pop_s    = OutValid & OutReady;
  assign Count    = count_r;

  // Show-ahead head read; forced to NOP when empty so stale storage never leaks.
  always_comb begin
    OutInstruction = {DATA_W{1'b0}};
    OutPCAddResult = {DATA_W{1'b0}};
    if (!empty_s) begin
      OutInstruction = instr_mem_r[rd_ptr_r];
      OutPCAddResult = pc_mem_r[rd_ptr_r];
    end else begin
      OutInstruction = {DATA_W{1'b0}};
      OutPCAddResult = {DATA_W{1'b0}};
    end
  end

  // Entry storage; contents are don't-care once pointers are cleared, so no reset.
  always_ff @(posedge Clk) begin
    if (push_s && !Flush && !Reset) begin
      instr_mem_r[wr_ptr_r] <= InInstruction;
      pc_mem_r[wr_ptr_r]    <= InPCAddResult;
    end
  end

  // Pointer and occupancy update; Reset outranks Flush, Flush outranks push/pop.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else if (Flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Scoreboard bench for instruction_fetch_queue. The stimulus process decides,
// from its own view of occupancy, which pushes the queue must accept and
// appends them to an expected-entry queue; a monitor samples the DUT mid-cycle,
// compares the head/flags against that queue and retires entries on pops.

module tb_instruction_fetch_queue;

  localparam int DEPTH  = 4;
  localparam int PTR_W  = 2;
  localparam int DATA_W = 32;

  logic              Clk;
  logic              Reset;
  logic              InValid;
  logic              InReady;
  logic [DATA_W-1:0] InInstruction;
  logic [DATA_W-1:0] InPCAddResult;
  logic              Flush;
  logic              OutValid;
  logic              OutReady;
  logic [DATA_W-1:0] OutInstruction;
  logic [DATA_W-1:0] OutPCAddResult;
  logic [PTR_W:0]    Count;

  instruction_fetch_queue #(
    .DEPTH(DEPTH), .PTR_W(PTR_W), .DATA_W(DATA_W)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .InValid(InValid), .InReady(InReady),
    .InInstruction(InInstruction), .InPCAddResult(InPCAddResult),
    .Flush(Flush),
    .OutValid(OutValid), .OutReady(OutReady),
    .OutInstruction(OutInstruction), .OutPCAddResult(OutPCAddResult),
    .Count(Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Expected contents of the queue, oldest first: {instruction, pc+4}.
  logic [2*DATA_W-1:0] exp_q[$];

  int   vectors = 0;
  int   miscompares = 0;
  bit   armed = 1'b0;

  // Transaction decided during the current cycle, committed at the next edge.
  bit              pend_clear = 1'b0;
  bit              pend_push  = 1'b0;
  logic [DATA_W-1:0] pend_ins = '0;
  logic [DATA_W-1:0] pend_pc  = '0;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Monitor: mid-cycle sample of the DUT against the expected queue.
  always @(negedge Clk) begin
    if (armed) begin
      int n;
      n = exp_q.size();
      check("count", DATA_W'(Count), DATA_W'(n));
      check("out_valid", DATA_W'(OutValid), DATA_W'(n != 0));
      check("in_ready", DATA_W'(InReady), DATA_W'(n != DEPTH));
      if (n > 0) begin
        check("out_instr", OutInstruction, exp_q[0][2*DATA_W-1:DATA_W]);
        check("out_pc", OutPCAddResult, exp_q[0][DATA_W-1:0]);
        if (OutReady && !Flush && !Reset) begin
          void'(exp_q.pop_front());
        end
      end else begin
        check("out_instr_nop", OutInstruction, 32'h0000_0000);
        check("out_pc_nop", OutPCAddResult, 32'h0000_0000);
      end
    end
  end

  // One clock cycle of stimulus: commit the last cycle's decision, drive the next.
  task automatic step(input logic v, input logic [DATA_W-1:0] ins,
                      input logic [DATA_W-1:0] pc, input logic rdy,
                      input logic fl, input logic rst);
    @(posedge Clk);
    if (pend_clear) begin
      exp_q.delete();
    end else if (pend_push) begin
      exp_q.push_back({pend_ins, pend_pc});
    end
    #1;
    InValid       = v;
    InInstruction = ins;
    InPCAddResult = pc;
    OutReady      = rdy;
    Flush         = fl;
    Reset         = rst;
    pend_clear    = fl || rst;
    pend_push     = v && (exp_q.size() < DEPTH) && !fl && !rst;
    pend_ins      = ins;
    pend_pc       = pc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    InValid = 1'b0; InInstruction = '0; InPCAddResult = '0;
    OutReady = 1'b0; Flush = 1'b0; Reset = 1'b1;

    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    armed = 1'b1;
    idle(1);

    // Single push then pop.
    step(1'b1, 32'h8C01_0004, 32'h0000_0004, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Fill to DEPTH, attempt a fifth push, then drain in order.
    for (int i = 1; i <= 4; i++)
      step(1'b1, 32'h1000_0000 + 32'(i), 32'(4 * i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hDEAD_BEEF, 32'h0000_0014, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Hold Count at 2 with simultaneous push/pop so pointers wrap.
    step(1'b1, 32'h2000_0001, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h2000_0002, 32'h0000_0104, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      step(1'b1, 32'h2000_0003 + 32'(i), 32'h0000_0108 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Flush with a concurrent push: the pushed word must not appear.
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h3000_0000 + 32'(i), 32'h0000_0200 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hBAD0_0001, 32'h0000_0BAD, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Reset while full with decode ready.
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'h4000_0000 + 32'(i), 32'h0000_0300 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hBAD0_0002, 32'h0000_0BAE, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Random traffic with occasional flushes and resets.
    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
           1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 31) == 0),
           1'($urandom_range(0, 63) == 0));
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
